sss_search_correlator: RTL and testbench
========================================

// Module: sss_search_correlator
// PURPOSE
//  Streaming SSS detector: slides a SEQ_LEN-bit window over a received bit stream and scores every
//  position against NUM_HYP stored local SSS sequences. Over WIN_LEN positions it reports the best
//  hypothesis, its offset and its match count via valid/ready. Sits after sync-bit demapping,
//  ahead of cell-ID decode.
// PARAMETERS
//  SEQ_LEN  62  chips per sequence (>=2)
//  NUM_HYP  4   stored local hypotheses (>=1)
//  WIN_LEN  8   window positions searched per run (>=1)
//  THRESH   56  res_detected asserts when best metric >= THRESH
//  Derived: HIDX_W=max(1,clog2(NUM_HYP)), OFF_W=max(1,clog2(WIN_LEN)), MET_W=clog2(SEQ_LEN+1)
// PORTS
//  clk           in   1        system clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  start         in   1        pulse: begin a search run (honoured in IDLE only)
//  abort         in   1        sync: drop the run, go IDLE, discard any result
//  hyp_wr_en     in   1        write a hypothesis (honoured in IDLE only)
//  hyp_wr_idx    in   HIDX_W   hypothesis slot; writes to slot >= NUM_HYP are ignored
//  hyp_wr_data   in   SEQ_LEN  local sequence; bit SEQ_LEN-1 = first chip on air
//  in_valid      in   1        received chip valid
//  in_bit        in   1        received chip
//  in_ready      out  1        chip accepted when in_valid && in_ready
//  busy          out  1        state != IDLE
//  res_valid     out  1        result available; held until res_ready
//  res_ready     in   1        result consumer ready
//  res_hyp       out  HIDX_W   winning hypothesis index
//  res_offset    out  OFF_W    winning position, 0..WIN_LEN-1
//  res_metric    out  MET_W    winning match count, 0..SEQ_LEN
//  res_detected  out  1        res_metric >= THRESH
//  res_inverted  out  1        winner matched the inverted sequence (feature only; else 0)
// BEHAVIOUR
//  - Reset: state IDLE; window, chip counter, best registers and hypothesis RAM cleared to 0;
//    all outputs 0.
//  - Window: an accepted chip shifts into win[0]; win[SEQ_LEN-1] is the oldest chip.
//    Per-hyp metric m_k = popcount(~(win ^ hyp[k])).
//  - FSM: IDLE -start-> FILL. FILL accepts chips; after SEQ_LEN chips -> SEARCH.
//    SEARCH: that chip and the next WIN_LEN-1 chips each produce one position (offset 0..WIN_LEN-1).
//    After the last position has been scored -> REPORT. REPORT: res_ready -> IDLE.
//  - in_ready = 1 in FILL, and in SEARCH until WIN_LEN positions are accepted; 0 in IDLE and REPORT.
//  - Pipeline: E0 = edge that accepts a chip (window updated). E1 = per-hyp metrics and offset tag
//    registered. E2 = best registers updated.
//  - Last position: after its E2 the state is REPORT, res_valid=1 and all res_* are final.
//    Latency = 2 cycles from the final accepted chip.
//  - Selection: a candidate replaces the best only if strictly greater. Ties go to the lowest
//    offset, then the lowest hyp index. Best is cleared to metric 0, hyp 0, offset 0 on start.
//  - res_* are stable while res_valid && !res_ready. res_valid drops the cycle after the handshake.
//  - Gaps in in_valid stall the run with no penalty; offsets count accepted chips only.
//  - abort: from any state -> IDLE next edge; res_valid=0; pipeline flushed; abort beats start.
//  - start in non-IDLE is ignored. start && hyp_wr_en in IDLE: the write lands and the run uses it.
//  - reset_n low mid-run: outputs clear asynchronously; no result is produced.
// CONFIGURATION
//  SSS_CORR_NEG_PEAK_EN defined: per-hyp score = max(m_k, SEQ_LEN-m_k). res_inverted=1 when the
//    SEQ_LEN-m_k term wins. On equal terms the non-inverted one wins (res_inverted=0).
//  Not defined: score = m_k; res_inverted tied to 0; no extra logic.
// TESTING  (SEQ_LEN=62, NUM_HYP=4, WIN_LEN=8, THRESH=56)
//  1 Load hyp0..3 with distinct PN patterns, hyp2=62'h2AAA_AAAA_AAAA_AAAA.
//    Stream 3 zeros + hyp2 chips (MSB first) + 4 zeros.
//    -> res_hyp=2, res_offset=3, res_metric=62, res_detected=1. res_valid 2 cycles after chip 69.
//  2 All hyps = 62'h2AAA_AAAA_AAAA_AAAA, stream 69 zeros
//    -> res_hyp=0, res_offset=0, res_metric=31, res_detected=0 (tie-break check).
//  3 Case 1 with res_ready held low 10 cycles -> res_* stable, in_ready=0, busy=1.
//    Raise res_ready -> res_valid=0 and busy=0 next cycle.
//  4 abort after 40 chips -> IDLE next edge, no res_valid. Then run case 1 -> identical result.
//    Also pulse start and abort together in IDLE -> stays IDLE.
//  5 reset_n low for 1 ns during SEARCH -> all outputs 0 immediately. Hypotheses cleared.
//    A new run with all-zero stream -> metric 62.
//  6 SSS_CORR_NEG_PEAK_EN: stream ~hyp1 at offset 0 -> res_hyp=1, res_inverted=1, res_metric=62.
//    Without the macro, hyp1 scores 0 and res_inverted=0.

Source files
------------

// File: rtl/sss_search_correlator.sv
// -----------------------------------------------------------------------------
// sss_search_correlator
//
// Streaming SSS detector. A SEQ_LEN-chip window slides over the received chip
// stream. Each of WIN_LEN consecutive window positions is scored against
// NUM_HYP locally stored sequences. The best (hypothesis, offset, match count)
// is reported through a valid/ready result port.
//
// Optional feature macro: SSS_CORR_NEG_PEAK_EN
//   defined   : score = max(m, SEQ_LEN-m); res_inverted flags the inverted term
//   undefined : score = m; res_inverted is constant 0
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   start, abort            run control (start honoured in IDLE; abort wins)
//   hyp_wr_en/idx/data      hypothesis load (IDLE only; out-of-range idx ignored)
//   in_valid/in_bit/in_ready  received chip stream
//   busy                    state != IDLE
//   res_valid/res_ready     result handshake
//   res_hyp/offset/metric   winning hypothesis, position and match count
//   res_detected            res_metric >= THRESH
//   res_inverted            winner matched the inverted sequence
// -----------------------------------------------------------------------------
module sss_search_correlator #(
    parameter int SEQ_LEN = 62,
    parameter int NUM_HYP = 4,
    parameter int WIN_LEN = 8,
    parameter int THRESH  = 56,
    localparam int HIDX_W = (NUM_HYP > 1) ? $clog2(NUM_HYP) : 1,
    localparam int OFF_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1,
    localparam int MET_W  = $clog2(SEQ_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               hyp_wr_en,
    input  logic [HIDX_W-1:0]  hyp_wr_idx,
    input  logic [SEQ_LEN-1:0] hyp_wr_data,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [HIDX_W-1:0]  res_hyp,
    output logic [OFF_W-1:0]   res_offset,
    output logic [MET_W-1:0]   res_metric,
    output logic               res_detected,
    output logic               res_inverted
);

    // Chips consumed per run: SEQ_LEN to fill, then WIN_LEN-1 more positions.
    localparam int CNT_W = $clog2(SEQ_LEN + WIN_LEN);
    localparam logic [CNT_W-1:0] FIRST_POS = CNT_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(SEQ_LEN + WIN_LEN - 2);
    localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(SEQ_LEN + WIN_LEN - 1);
    localparam logic [31:0]      THRESH_U  = THRESH;
    localparam logic [MET_W-1:0] SEQ_LEN_M = MET_W'(SEQ_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t             state_reg;
    logic [SEQ_LEN-1:0] win_reg;
    logic [CNT_W-1:0]   chip_cnt_reg;

    // Stage 0: tag of the chip just shifted into the window.
    logic               s0_valid_reg;
    logic               s0_last_reg;
    logic [OFF_W-1:0]   s0_off_reg;
    // Stage 1: registered per-hypothesis scores for that position.
    logic               s1_valid_reg;
    logic               s1_last_reg;
    logic [OFF_W-1:0]   s1_off_reg;
    logic [MET_W-1:0]   s1_score [NUM_HYP];
    logic               s1_inv   [NUM_HYP];

    logic [MET_W-1:0]   best_metric_reg;
    logic [HIDX_W-1:0]  best_hyp_reg;
    logic [OFF_W-1:0]   best_off_reg;
    logic               best_inv_reg;
    logic               res_valid_reg;

    logic               accept;
    logic [MET_W-1:0]   cand_metric_c;
    logic [HIDX_W-1:0]  cand_hyp_c;
    logic               cand_inv_c;

    function automatic logic [MET_W-1:0] popcount(input logic [SEQ_LEN-1:0] v);
        logic [MET_W-1:0] n;
        n = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            n = n + MET_W'(v[i]);
        end
        return n;
    endfunction

    assign in_ready = (state_reg == ST_FILL) ||
                      ((state_reg == ST_SEARCH) && (chip_cnt_reg < TOTAL));
    assign accept   = in_valid && in_ready;

    // Per-hypothesis storage and scoring.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HYP; gi++) begin : g_hyp
            logic [SEQ_LEN-1:0] hyp_reg;
            logic [MET_W-1:0]   match_c;
            logic [MET_W-1:0]   score_c;
            logic               inv_c;
            logic [MET_W-1:0]   score_reg;
            logic               inv_reg;

            // Slots beyond NUM_HYP never match an index here, so such writes drop.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hyp_reg <= '0;
                end else if ((state_reg == ST_IDLE) && hyp_wr_en &&
                             (hyp_wr_idx == HIDX_W'(gi))) begin
                    hyp_reg <= hyp_wr_data;
                end
            end

            always_comb begin
                match_c = popcount(~(win_reg ^ hyp_reg));
`ifdef SSS_CORR_NEG_PEAK_EN
                // Equal terms keep the non-inverted reading.
                if ((SEQ_LEN_M - match_c) > match_c) begin
                    score_c = SEQ_LEN_M - match_c;
                    inv_c   = 1'b1;
                end else begin
                    score_c = match_c;
                    inv_c   = 1'b0;
                end
`else
                score_c = match_c;
                inv_c   = 1'b0;
`endif
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    score_reg <= '0;
                    inv_reg   <= 1'b0;
                end else begin
                    score_reg <= score_c;
                    inv_reg   <= inv_c;
                end
            end

            assign s1_score[gi] = score_reg;
            assign s1_inv[gi]   = inv_reg;
        end
    endgenerate

    // Best hypothesis of the current position; strict '>' keeps the lowest index.
    always_comb begin
        cand_metric_c = s1_score[0];
        cand_hyp_c    = '0;
        cand_inv_c    = s1_inv[0];
        for (int k = 1; k < NUM_HYP; k++) begin
            if (s1_score[k] > cand_metric_c) begin
                cand_metric_c = s1_score[k];
                cand_hyp_c    = HIDX_W'(k);
                cand_inv_c    = s1_inv[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            win_reg         <= '0;
            chip_cnt_reg    <= '0;
            s0_valid_reg    <= 1'b0;
            s0_last_reg     <= 1'b0;
            s0_off_reg      <= '0;
            s1_valid_reg    <= 1'b0;
            s1_last_reg     <= 1'b0;
            s1_off_reg      <= '0;
            best_metric_reg <= '0;
            best_hyp_reg    <= '0;
            best_off_reg    <= '0;
            best_inv_reg    <= 1'b0;
            res_valid_reg   <= 1'b0;
        end else if (abort) begin
            // Flush: positions still in flight must not reach the best registers.
            state_reg     <= ST_IDLE;
            res_valid_reg <= 1'b0;
            s0_valid_reg  <= 1'b0;
            s0_last_reg   <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
        end else begin
            if (accept) begin
                win_reg      <= {win_reg[SEQ_LEN-2:0], in_bit};
                chip_cnt_reg <= chip_cnt_reg + CNT_W'(1);
            end

            // Offset is the count of accepted chips past the fill point.
            s0_valid_reg <= accept && (chip_cnt_reg >= FIRST_POS);
            s0_last_reg  <= accept && (chip_cnt_reg == LAST_POS);
            s0_off_reg   <= OFF_W'(chip_cnt_reg - FIRST_POS);

            s1_valid_reg <= s0_valid_reg;
            s1_last_reg  <= s0_last_reg;
            s1_off_reg   <= s0_off_reg;

            // Offsets arrive in ascending order, so strict '>' favours the lowest offset.
            if (s1_valid_reg && (cand_metric_c > best_metric_reg)) begin
                best_metric_reg <= cand_metric_c;
                best_hyp_reg    <= cand_hyp_c;
                best_off_reg    <= s1_off_reg;
                best_inv_reg    <= cand_inv_c;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg       <= ST_FILL;
                        chip_cnt_reg    <= '0;
                        best_metric_reg <= '0;
                        best_hyp_reg    <= '0;
                        best_off_reg    <= '0;
                        best_inv_reg    <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (accept && (chip_cnt_reg == FIRST_POS)) begin
                        state_reg <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (s1_valid_reg && s1_last_reg) begin
                        state_reg     <= ST_REPORT;
                        res_valid_reg <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        state_reg     <= ST_IDLE;
                        res_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign res_valid    = res_valid_reg;
    assign res_hyp      = best_hyp_reg;
    assign res_offset   = best_off_reg;
    assign res_metric   = best_metric_reg;
    assign res_inverted = best_inv_reg;
    assign res_detected = res_valid_reg && ({{(32-MET_W){1'b0}}, best_metric_reg} >= THRESH_U);

endmodule

// File: tb/tb_sss_search_correlator.sv
// -----------------------------------------------------------------------------
// Testbench for sss_search_correlator (SEQ_LEN=62, NUM_HYP=4, WIN_LEN=8,
// THRESH=56). Results are predicted by a direct sliding-window correlation
// over the stimulus queue and the stored hypothesis copies.
// -----------------------------------------------------------------------------
module tb_sss_search_correlator;

    localparam int SEQ_LEN = 62;
    localparam int NUM_HYP = 4;
    localparam int WIN_LEN = 8;
    localparam int THRESH  = 56;
    localparam logic [61:0] HYP_AA = 62'h2AAA_AAAA_AAAA_AAAA;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hyp_wr_en = 1'b0;
    logic [1:0]  hyp_wr_idx = '0;
    logic [61:0] hyp_wr_data = '0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        res_ready = 1'b0;
    logic        in_ready, busy, res_valid, res_detected, res_inverted;
    logic [1:0]  res_hyp;
    logic [2:0]  res_offset;
    logic [5:0]  res_metric;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [61:0] hyp_m [NUM_HYP];
    bit          stream_q[$];

    wire [12:0] dut_tuple = {res_hyp, res_offset, res_metric, res_detected, res_inverted};

    sss_search_correlator #(
        .SEQ_LEN(SEQ_LEN), .NUM_HYP(NUM_HYP), .WIN_LEN(WIN_LEN), .THRESH(THRESH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .hyp_wr_en(hyp_wr_en), .hyp_wr_idx(hyp_wr_idx), .hyp_wr_data(hyp_wr_data),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_hyp(res_hyp),
        .res_offset(res_offset), .res_metric(res_metric),
        .res_detected(res_detected), .res_inverted(res_inverted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_search(output int eh, output int eo, output int em, output bit ei);
        eh = 0; eo = 0; em = 0; ei = 1'b0;
        for (int off = 0; off < WIN_LEN; off++) begin
            for (int h = 0; h < NUM_HYP; h++) begin
                int m;
                int s;
                bit inv;
                m = 0;
                for (int j = 0; j < SEQ_LEN; j++) begin
                    if (stream_q[off + j] == hyp_m[h][SEQ_LEN-1-j]) m++;
                end
                s = m;
                inv = 1'b0;
`ifdef SSS_CORR_NEG_PEAK_EN
                if (SEQ_LEN - m > m) begin
                    s = SEQ_LEN - m;
                    inv = 1'b1;
                end
`endif
                if (s > em) begin
                    em = s; eh = h; eo = off; ei = inv;
                end
            end
        end
    endfunction

    function automatic logic [12:0] pack_res(input int h, input int o, input int m, input bit i);
        return {2'(h), 3'(o), 6'(m), (m >= THRESH) ? 1'b1 : 1'b0, i};
    endfunction

    function automatic logic [12:0] model_tuple();
        int h, o, m;
        bit i;
        model_search(h, o, m, i);
        return pack_res(h, o, m, i);
    endfunction

    function automatic string tup_str(input logic [12:0] t);
        return $sformatf("hyp=%0d off=%0d met=%0d det=%0d inv=%0d",
                         t[12:11], t[10:8], t[7:2], t[1], t[0]);
    endfunction

    function automatic logic [61:0] rand62();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[61:0];
    endfunction

    // ---------------- stimulus helpers (all start and end at a negedge) ----------------
    task automatic load_hyp(input logic [1:0] idx, input logic [61:0] data);
        hyp_wr_en = 1'b1; hyp_wr_idx = idx; hyp_wr_data = data;
        @(negedge clk);
        hyp_wr_en = 1'b0;
        hyp_m[idx] = data;
    endtask

    task automatic feed_chips(input int n, input bit gaps, output bit ok);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 1000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_bit = stream_q[idx];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        ok = (idx == n);
    endtask

    task automatic run_search(input bit gaps, input bit wr, input logic [1:0] widx,
                              input logic [61:0] wdata, output int lat, output bit ok);
        res_ready = 1'b0;
        start = 1'b1;
        if (wr) begin
            hyp_wr_en = 1'b1; hyp_wr_idx = widx; hyp_wr_data = wdata;
            hyp_m[widx] = wdata;
        end
        @(negedge clk);
        start = 1'b0;
        hyp_wr_en = 1'b0;
        feed_chips(stream_q.size(), gaps, ok);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = ok && res_valid;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic load_case1_hyps();
        load_hyp(2'd0, 62'h1234_5678_9ABC_DEF0 ^ rand62());
        load_hyp(2'd1, 62'h0F0F_3C3C_5A5A_9696 ^ rand62());
        load_hyp(2'd2, HYP_AA);
        load_hyp(2'd3, 62'h3333_CCCC_0FF0_F00F ^ rand62());
    endtask

    task automatic make_case1_stream();
        stream_q.delete();
        repeat (3) stream_q.push_back(1'b0);
        for (int j = SEQ_LEN - 1; j >= 0; j--) stream_q.push_back(hyp_m[2][j]);
        repeat (4) stream_q.push_back(1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        vec_cnt++;
        if (dut_tuple !== 13'd0 || {busy, in_ready, res_valid} !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_async: got %s busy=%0b rdy=%0b vld=%0b, expected all 0",
                     tup_str(dut_tuple), busy, in_ready, res_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int h = 0; h < NUM_HYP; h++) hyp_m[h] = '0;
        @(negedge clk);
        vec_cnt++;
        if ({busy, in_ready, res_valid, dut_tuple} !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_idle: got %s busy=%0b rdy=%0b vld=%0b, expected all 0",
                     tup_str(dut_tuple), busy, in_ready, res_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_detect();
        int lat;
        bit ok;
        logic [12:0] exp_t;
        load_case1_hyps();
        make_case1_stream();
        exp_t = model_tuple();
        run_search(1'b0, 1'b0, 2'd0, 62'd0, lat, ok);
        vec_cnt++;
        if (!ok || lat != 2) begin
            err_cnt++;
            $display("FAIL detect_latency: got ok=%0b lat=%0d, expected ok=1 lat=2", ok, lat);
        end
        vec_cnt++;
        if (dut_tuple !== exp_t) begin
            err_cnt++;
            $display("FAIL detect_model: got %s, expected %s", tup_str(dut_tuple), tup_str(exp_t));
        end
        vec_cnt++;
        if (dut_tuple !== pack_res(2, 3, 62, 1'b0)) begin
            err_cnt++;
            $display("FAIL detect_case1: got %s, expected %s", tup_str(dut_tuple), tup_str(pack_res(2, 3, 62, 1'b0)));
        end
        handshake();
        $display("test_detect: %s", tup_str(dut_tuple));
    endtask

    task automatic test_tie_break();
        int lat;
        bit ok;
        for (int h = 0; h < NUM_HYP; h++) load_hyp(2'(h), HYP_AA);
        stream_q.delete();
        repeat (SEQ_LEN + WIN_LEN - 1) stream_q.push_back(1'b0);
        run_search(1'b0, 1'b0, 2'd0, 62'd0, lat, ok);
        vec_cnt++;
        if (!ok || dut_tuple !== model_tuple() || dut_tuple !== pack_res(0, 0, 31, 1'b0)) begin
            err_cnt++;
            $display("FAIL tie_break: got ok=%0b %s, expected %s", ok, tup_str(dut_tuple), tup_str(pack_res(0, 0, 31, 1'b0)));
        end
        handshake();
        $display("test_tie_break: %s", tup_str(dut_tuple));
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        logic [12:0] exp_t;
        load_case1_hyps();
        make_case1_stream();
        exp_t = model_tuple();
        run_search(1'b0, 1'b0, 2'd0, 62'd0, lat, ok);
        for (int c = 0; c < 10; c++) begin
            vec_cnt++;
            if (!ok || {res_valid, in_ready, busy, dut_tuple} !== {3'b101, exp_t}) begin
                err_cnt++;
                $display("FAIL hold_cycle%0d: got vld=%0b rdy=%0b busy=%0b %s, expected vld=1 rdy=0 busy=1 %s",
                         c, res_valid, in_ready, busy, tup_str(dut_tuple), tup_str(exp_t));
            end
            @(negedge clk);
        end
        handshake();
        vec_cnt++;
        if ({res_valid, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL release: got vld=%0b busy=%0b, expected 0 0", res_valid, busy);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        bit ok;
        logic [12:0] exp_t;
        make_case1_stream();
        exp_t = model_tuple();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_chips(40, 1'b0, ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vec_cnt++;
        if (!ok || {busy, res_valid, in_ready} !== 3'b000) begin
            err_cnt++;
            $display("FAIL abort_idle: got ok=%0b busy=%0b vld=%0b rdy=%0b, expected 1 0 0 0", ok, busy, res_valid, in_ready);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        vec_cnt++;
        if (seen != 0) begin
            err_cnt++;
            $display("FAIL abort_quiet: got %0d active cycles, expected 0", seen);
        end
        run_search(1'b0, 1'b0, 2'd0, 62'd0, lat, ok);
        vec_cnt++;
        if (!ok || dut_tuple !== exp_t) begin
            err_cnt++;
            $display("FAIL abort_rerun: got ok=%0b %s, expected %s", ok, tup_str(dut_tuple), tup_str(exp_t));
        end
        handshake();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_abort: got busy=%0b, expected 0", busy);
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit ok;
        make_case1_stream();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_chips(65, 1'b0, ok);
        #2 reset_n = 1'b0;
        #1;
        vec_cnt++;
        if (!ok || {busy, in_ready, res_valid, dut_tuple} !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_mid: got ok=%0b busy=%0b rdy=%0b vld=%0b %s, expected all 0",
                     ok, busy, in_ready, res_valid, tup_str(dut_tuple));
        end
        reset_n = 1'b1;
        for (int h = 0; h < NUM_HYP; h++) hyp_m[h] = '0;
        @(negedge clk);
        stream_q.delete();
        repeat (SEQ_LEN + WIN_LEN - 1) stream_q.push_back(1'b0);
        run_search(1'b0, 1'b0, 2'd0, 62'd0, lat, ok);
        vec_cnt++;
        if (!ok || dut_tuple !== pack_res(0, 0, 62, 1'b0) || dut_tuple !== model_tuple()) begin
            err_cnt++;
            $display("FAIL reset_cleared_hyps: got ok=%0b %s, expected %s", ok, tup_str(dut_tuple), tup_str(pack_res(0, 0, 62, 1'b0)));
        end
        handshake();
        $display("test_reset_mid_run done");
    endtask

    task automatic test_neg_peak();
        int lat;
        bit ok;
        logic [12:0] exp_t;
        for (int h = 0; h < NUM_HYP; h++) load_hyp(2'(h), rand62());
        stream_q.delete();
        for (int j = SEQ_LEN - 1; j >= 0; j--) stream_q.push_back(~hyp_m[1][j]);
        repeat (WIN_LEN - 1) stream_q.push_back(1'($urandom_range(0, 1)));
        exp_t = model_tuple();
        run_search(1'b0, 1'b0, 2'd0, 62'd0, lat, ok);
        vec_cnt++;
        if (!ok || dut_tuple !== exp_t) begin
            err_cnt++;
            $display("FAIL neg_model: got ok=%0b %s, expected %s", ok, tup_str(dut_tuple), tup_str(exp_t));
        end
`ifdef SSS_CORR_NEG_PEAK_EN
        vec_cnt++;
        if (dut_tuple !== pack_res(1, 0, 62, 1'b1)) begin
            err_cnt++;
            $display("FAIL neg_peak: got %s, expected %s", tup_str(dut_tuple), tup_str(pack_res(1, 0, 62, 1'b1)));
        end
`else
        vec_cnt++;
        if (res_inverted !== 1'b0 || (res_hyp === 2'd1 && res_offset === 3'd0)) begin
            err_cnt++;
            $display("FAIL neg_off: got %s, expected inv=0 and not hyp1/off0", tup_str(dut_tuple));
        end
`endif
        handshake();
        $display("test_neg_peak: %s", tup_str(dut_tuple));
    endtask

    task automatic test_random();
        int lat;
        bit ok;
        logic [12:0] exp_t;
        logic [1:0]  widx;
        logic [61:0] wdata;
        int off, h, flips;
        for (int run = 0; run < 8; run++) begin
            for (int k = 0; k < NUM_HYP; k++) load_hyp(2'(k), rand62());
            widx = 2'($urandom_range(0, NUM_HYP - 1));
            wdata = rand62();
            hyp_m[widx] = wdata;
            stream_q.delete();
            repeat (SEQ_LEN + WIN_LEN - 1) stream_q.push_back(1'($urandom_range(0, 1)));
            off = $urandom_range(0, WIN_LEN - 1);
            h = $urandom_range(0, NUM_HYP - 1);
            for (int j = 0; j < SEQ_LEN; j++) stream_q[off + j] = hyp_m[h][SEQ_LEN-1-j];
            flips = $urandom_range(0, 9);
            for (int f = 0; f < flips; f++) begin
                int p;
                p = off + $urandom_range(0, SEQ_LEN - 1);
                stream_q[p] = ~stream_q[p];
            end
            exp_t = model_tuple();
            run_search(1'b1, 1'b1, widx, wdata, lat, ok);
            vec_cnt++;
            if (!ok || lat != 2 || dut_tuple !== exp_t) begin
                err_cnt++;
                $display("FAIL random%0d: got ok=%0b lat=%0d %s, expected lat=2 %s",
                         run, ok, lat, tup_str(dut_tuple), tup_str(exp_t));
            end
            handshake();
            $display("random run %0d: %s", run, tup_str(dut_tuple));
        end
    endtask

    initial begin
        test_reset();
        test_detect();
        test_tie_break();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        test_neg_peak();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
